// File: rtl/fifo_ptrs_pkg.sv
// rtl/fifo_ptrs_pkg.sv - shared sizing helper for the FIFO pointer engine
package fifo_ptrs_pkg;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   function automatic int ptr_width(input int log_depth);
      return log_depth + 1;
   endfunction

endpackage

// File: rtl/fifo_ptrs_delay.sv
// rtl/fifo_ptrs_delay.sv - fixed-length register pipeline producing the committed write pointer
module fifo_ptrs_delay #(
   parameter int WIDTH = 4,
   parameter int DELAY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] ptr,
   output logic [WIDTH-1:0] delayed_ptr
);

   generate
      if (DELAY == 0) begin : g_pass
         assign delayed_ptr = ptr;
      end else begin : g_pipe
         logic [WIDTH-1:0] stages [DELAY];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int i = 0; i < DELAY; i++) begin
                  stages[i] <= '0;
               end
            end else begin
               stages[0] <= ptr;
               for (int i = 1; i < DELAY; i++) begin
                  stages[i] <= stages[i-1];
               end
            end
         end

         assign delayed_ptr = stages[DELAY-1];
      end
   endgenerate

endmodule

// File: rtl/fifo_ptrs.sv
// rtl/fifo_ptrs.sv - write/read pointer and flow-control engine for a storage-less FIFO
module fifo_ptrs
   import fifo_ptrs_pkg::*;
#(
   parameter int LOG_DEPTH         = 3,
   parameter int WRITE_DELAY       = 2,
   parameter int ALMOST_FULL_SLACK = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wrreq,
   output logic                 almost_full,
   output logic [LOG_DEPTH-1:0] wraddr,
   input  logic                 rdreq,
   output logic                 empty,
   output logic [LOG_DEPTH-1:0] rdaddr
);

   localparam int PW       = ptr_width(LOG_DEPTH);
   localparam int DEPTH    = 1 << LOG_DEPTH;
   localparam int AF_LEVEL = DEPTH - ALMOST_FULL_SLACK;

   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic [PW-1:0] cwp;
   logic [PW-1:0] occupancy;
   logic          wr_accept;
   logic          rd_accept;

   // Illegal requests (write while almost full, read while empty) are dropped here.
   assign wr_accept = wrreq && !almost_full;
   assign rd_accept = rdreq && !empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr_accept) begin
            wp <= wp + PW'(1);
         end
         if (rd_accept) begin
            rp <= rp + PW'(1);
         end
      end
   end

   fifo_ptrs_delay #(
      .WIDTH (PW),
      .DELAY (WRITE_DELAY)
   ) u_delay (
      .clk         (clk),
      .rst         (rst),
      .ptr         (wp),
      .delayed_ptr (cwp)
   );

   // Occupancy uses the uncommitted wp so in-flight writes still reserve RAM slots.
   assign occupancy   = wp - rp;
   assign almost_full = (occupancy >= PW'(AF_LEVEL));
   assign empty       = (cwp == rp);
   assign wraddr      = wp[LOG_DEPTH-1:0];
   assign rdaddr      = rp[LOG_DEPTH-1:0];

endmodule

// File: tb/tb_fifo_ptrs.sv
// tb/tb_fifo_ptrs.sv - self-checking bench for fifo_ptrs
module tb_fifo_ptrs;

   localparam int LD    = 3;
   localparam int DEPTH = 8;
   localparam int WD    = 2;
   localparam int SLACK = 0;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wrreq = 1'b0;
   logic          rdreq = 1'b0;
   logic          almost_full;
   logic          empty;
   logic [LD-1:0] wraddr;
   logic [LD-1:0] rdaddr;

   logic          wrreq_z = 1'b0;
   logic          rdreq_z = 1'b0;
   logic          almost_full_z;
   logic          empty_z;
   logic [LD-1:0] wraddr_z;
   logic [LD-1:0] rdaddr_z;

   always #5 clk = ~clk;

   fifo_ptrs #(.LOG_DEPTH(LD), .WRITE_DELAY(WD), .ALMOST_FULL_SLACK(SLACK)) dut (
      .clk(clk), .rst(rst), .wrreq(wrreq), .almost_full(almost_full), .wraddr(wraddr),
      .rdreq(rdreq), .empty(empty), .rdaddr(rdaddr)
   );

   fifo_ptrs #(.LOG_DEPTH(LD), .WRITE_DELAY(0), .ALMOST_FULL_SLACK(0)) dut_z (
      .clk(clk), .rst(rst), .wrreq(wrreq_z), .almost_full(almost_full_z), .wraddr(wraddr_z),
      .rdreq(rdreq_z), .empty(empty_z), .rdaddr(rdaddr_z)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: each stored entry is remembered by the cycle it becomes readable.
   int cyc = 0;
   int q[$];
   int wr_total = 0;
   int rd_total = 0;

   typedef struct {
      logic wr;
      logic rd;
      logic e;
      logic af;
      int   wa;
      int   ra;
   } vec_t;

   vec_t tv[9];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit model_empty();
      return (q.size() == 0) || (q[0] > cyc);
   endfunction

   function automatic bit model_af();
      return q.size() >= DEPTH - SLACK;
   endfunction

   task automatic model_reset();
      q.delete();
      wr_total = 0;
      rd_total = 0;
      cyc      = 0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".empty"}, int'(empty), int'(model_empty()));
      chk({tag, ".almost_full"}, int'(almost_full), int'(model_af()));
      chk({tag, ".wraddr"}, int'(wraddr), wr_total % DEPTH);
      chk({tag, ".rdaddr"}, int'(rdaddr), rd_total % DEPTH);
   endtask

   // Called at a falling edge: check state, drive one cycle of requests, advance.
   task automatic tick(input logic w, input logic r);
      bit e;
      bit af;
      check_model("model");
      e  = model_empty();
      af = model_af();
      wrreq = w;
      rdreq = r;
      if (w && !af) begin
         q.push_back(cyc + 1 + WD);
         wr_total++;
      end
      if (r && !e) begin
         void'(q.pop_front());
         rd_total++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, ".empty"}, int'(empty), 1);
      chk({tag, ".almost_full"}, int'(almost_full), 0);
      chk({tag, ".wraddr"}, int'(wraddr), 0);
      chk({tag, ".rdaddr"}, int'(rdaddr), 0);
   endtask

   task automatic do_reset(input int cycles);
      rst     = 1'b0;
      wrreq   = 1'b0;
      rdreq   = 1'b0;
      wrreq_z = 1'b0;
      rdreq_z = 1'b0;
      repeat (cycles) @(negedge clk);
      check_reset_values("reset_hold");
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      bit prod_on;
      bit cons_on;
      int prod_left;
      int cons_left;
      int sent;
      int got;
      int guard;
      logic w;
      logic r;

      tv[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
      tv[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
      tv[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0};
      tv[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0};
      tv[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 1};
      tv[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1};
      tv[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1};
      tv[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 1};
      tv[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 2};

      @(negedge clk);
      do_reset(50);

      for (int i = 0; i < 9; i++) begin
         chk($sformatf("vec%0d.empty", i), int'(empty), int'(tv[i].e));
         chk($sformatf("vec%0d.almost_full", i), int'(almost_full), int'(tv[i].af));
         chk($sformatf("vec%0d.wraddr", i), int'(wraddr), tv[i].wa);
         chk($sformatf("vec%0d.rdaddr", i), int'(rdaddr), tv[i].ra);
         tick(tv[i].wr, tv[i].rd);
      end

      // Fill to capacity, try an illegal ninth write, then free one slot.
      do_reset(2);
      for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b0);
      chk("fill.almost_full", int'(almost_full), 1);
      chk("fill.wraddr_wrapped", int'(wraddr), 0);
      tick(1'b1, 1'b0);
      chk("fill.ninth_ignored", int'(wraddr), 0);
      chk("fill.still_full", int'(almost_full), 1);
      tick(1'b0, 1'b1);
      chk("fill.af_drops", int'(almost_full), 0);
      chk("fill.rdaddr", int'(rdaddr), 1);

      // Seven entries held steady under simultaneous read and write.
      do_reset(2);
      for (int i = 0; i < 7; i++) tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         chk("simul.almost_full", int'(almost_full), 0);
         tick(1'b1, 1'b1);
      end
      chk("simul.occupancy", q.size(), 7);
      chk("simul.wraddr", int'(wraddr), 27 % DEPTH);
      chk("simul.rdaddr", int'(rdaddr), 20 % DEPTH);

      // Asynchronous reset in the middle of random traffic.
      for (int i = 0; i < 30; i++) tick(1'($urandom), 1'($urandom));
      wrreq = 1'b1;
      rdreq = 1'b1;
      #2 rst = 1'b0;
      #1 check_reset_values("midreset");
      @(posedge clk);
      wrreq = 1'b0;
      rdreq = 1'b0;
      @(negedge clk);
      check_reset_values("midreset_held");
      rst = 1'b1;
      model_reset();
      tick(1'b1, 1'b0);
      chk("restart.wraddr", int'(wraddr), 1);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      chk("restart.empty", int'(empty), 0);
      tick(1'b0, 1'b1);
      chk("restart.drained", int'(empty), 1);

      // Randomised producer/consumer with on/off bursts.
      do_reset(2);
      prod_on   = 1'b0;
      cons_on   = 1'b0;
      prod_left = 0;
      cons_left = 0;
      sent      = 0;
      got       = 0;
      guard     = 0;
      while ((sent < 3000 || got < 3000) && guard < 60000) begin
         if (prod_left == 0) begin
            prod_on   = !prod_on;
            prod_left = $urandom_range(1, 10);
         end
         if (cons_left == 0) begin
            cons_on   = !cons_on;
            cons_left = $urandom_range(1, 10);
         end
         w = prod_on && (sent < 3000) && !almost_full;
         r = cons_on;
         if (w) sent++;
         if (r && !empty) got++;
         tick(w, r);
         prod_left--;
         cons_left--;
         guard++;
      end
      chk("stress.within_budget", int'(guard < 60000), 1);
      chk("stress.sent", sent, 3000);
      chk("stress.received", got, 3000);
      chk("stress.model_reads", rd_total, 3000);
      check_model("stress.final");

      // Zero write delay: the entry is readable the cycle after the write.
      do_reset(2);
      chk("wd0.reset_empty", int'(empty_z), 1);
      wrreq_z = 1'b1;
      @(negedge clk);
      wrreq_z = 1'b0;
      chk("wd0.empty_next_cycle", int'(empty_z), 0);
      chk("wd0.wraddr", int'(wraddr_z), 1);
      rdreq_z = 1'b1;
      @(negedge clk);
      rdreq_z = 1'b0;
      chk("wd0.empty_after_read", int'(empty_z), 1);
      chk("wd0.rdaddr", int'(rdaddr_z), 1);
      chk("wd0.almost_full", int'(almost_full_z), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_ptrs.md
# fifo_ptrs

Pointer and flow-control engine for a storage-less FIFO of 2^LOG_DEPTH entries. It tracks write and read pointers and produces `almost_full` for the producer and `empty` for the consumer. Writes become visible to the read side only after a fixed WRITE_DELAY, which matches the latency of the external data RAM write path. It sits beside a RAM inside every Kanagawa FIFO wrapper.

## Interface
- LOG_DEPTH, default 3: log2 of FIFO capacity; DEPTH = 2^LOG_DEPTH.
- WRITE_DELAY, default 2: extra cycles (≥0) before a write is visible to the read side.
- ALMOST_FULL_SLACK, default 0: `almost_full` asserts when write-side occupancy ≥ DEPTH − ALMOST_FULL_SLACK.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- wrreq  in  1  producer pushes one entry this cycle.
- almost_full  out  1  producer must not assert `wrreq`.
- wraddr  out  LOG_DEPTH  RAM address for the current write.
- rdreq  in  1  consumer pops the head entry this cycle.
- empty  out  1  no committed entry available.
- rdaddr  out  LOG_DEPTH  RAM address of the head entry.

## Operation
- Pointers are LOG_DEPTH+1 bits wide, with the extra MSB used for wrap detection. They increment modulo 2^(LOG_DEPTH+1). `wraddr` and `rdaddr` are the low LOG_DEPTH bits.
- Write pointer `wp`:
  - Increments on an accepted write, i.e. `wrreq && !almost_full`.
  - `wrreq` while `almost_full` is illegal. It is ignored: no pointer change.
- Committed write pointer `cwp`:
  - Equals `wp` delayed by WRITE_DELAY registered stages.
  - With WRITE_DELAY = 0, `cwp` equals `wp`.
- Read pointer `rp`:
  - Increments on an accepted read, i.e. `rdreq && !empty`.
  - `rdreq` while `empty` is illegal. It is ignored.
- Outputs:
  - `empty` = (`cwp` == `rp`), combinational from registers.
  - `almost_full` = (`wp` − `rp`) ≥ DEPTH − ALMOST_FULL_SLACK, combinational from registers.
- Write-side occupancy (`wp` − `rp`) counts in-flight writes, so the RAM can never be overrun.
- Simultaneous accepted read and write: both pointers advance and occupancy is unchanged.
- Reset (any time, including mid-traffic): all pointers and delay stages go to 0.
  - Outputs during and after reset: `empty` = 1, `almost_full` = 0, `wraddr` = `rdaddr` = 0.
  - In-flight delayed writes are discarded.

## Timing
- Accepted write in cycle t:
  - `wraddr` advances in cycle t+1.
  - Entry counts toward `almost_full` in cycle t+1.
  - `empty` can fall no earlier than cycle t+1+WRITE_DELAY.
- Accepted read in cycle r: `rdaddr` advances and `almost_full` can fall in cycle r+1.
- Minimum write-to-read latency is 1+WRITE_DELAY cycles: 3 cycles at the defaults.
- Full throughput is one write and one read per cycle.
- No combinational path from `wrreq`/`rdreq` to any output.

## Structure
- Shared package holds only a function computing pointer width (LOG_DEPTH+1). No typedefs are needed.
- One natural sub-module, `fifo_ptrs_delay`: a WRITE_DELAY-stage register pipeline (width LOG_DEPTH+1, async active-low reset to 0) that produces `cwp`. It is pass-through at delay 0.

## Test plan
- Reset:
  - Hold `rst`=0 for 50 cycles; require `empty`=1, `almost_full`=0, both addresses 0.
  - Assert `rst`=0 mid-traffic; require the same values immediately and a clean restart afterward.
- Single write at defaults, `wrreq` in cycle 0: `empty` falls in cycle 3; `wraddr`=1 from cycle 1; one `rdreq` then restores `empty`=1 and `rdaddr`=1.
- Fill without reads: 8 consecutive writes.
  - `almost_full`=1 from the cycle after the 8th write.
  - A 9th `wrreq` is ignored (`wraddr` stays 0, wrapped).
  - One read drops `almost_full` the next cycle.
- Full and simultaneous: with 7 entries, `wrreq`=`rdreq`=1 for 20 cycles; occupancy stays at 7 and `almost_full` never asserts.
- Randomised stress:
  - 3000 writes from a producer and a consumer, each with random 1–10-cycle stalls and on/off periods.
  - The consumer must receive exactly 3000 entries.
  - Pointers must wrap many times with no overflow or underflow.
- WRITE_DELAY = 0 variant: a single write must clear `empty` one cycle after the write.
